gray_sync_decoder: RTL and testbench



---
 rtl/gray_sync_decoder.sv | 98 +++++++++
 tb/tb_gray_sync_decoder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/gray_sync_decoder.sv
// Gray-code receive path: flop-chain synchronizer, Gray-to-binary, update strobe and
// optional illegal-step detection (compiled in with `define GRAY_STEP_CHECK_EN).
module gray_sync_decoder #(
    parameter int unsigned SIZE        = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic            clk_i,
    input  logic            srst_i,
    input  logic [SIZE-1:0] gray_i,
    input  logic            err_clr_i,
    output logic [SIZE-1:0] bin_o,
    output logic            bin_valid_o,
    output logic            changed_o,
    output logic            step_err_o
);

    localparam int unsigned CNT_W = $clog2(SYNC_STAGES + 2);
    localparam logic [CNT_W-1:0] FILL_MAX = CNT_W'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0][SIZE-1:0] r_sync;
    logic [SIZE-1:0]                  r_bin;
    logic [CNT_W-1:0]                 r_fill;
    logic                             r_valid;
    logic                             r_changed;

    logic [SIZE-1:0]  w_gray;
    logic [SIZE-1:0]  w_bin;
    logic [CNT_W-1:0] w_fill_nxt;
    logic             w_changed;

    // Plain flop chain; stage 0 is the metastability-capturing flop.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], gray_i};
        end
    end

    assign w_gray = r_sync[SYNC_STAGES-1];

    // Each binary bit is the XOR of all Gray bits at and above it.
    always_comb begin
        w_bin = '0;
        for (int unsigned k = 0; k < SIZE; k++) begin
            w_bin[k] = ^(w_gray >> k);
        end
    end

    assign w_fill_nxt = (r_fill == FILL_MAX) ? r_fill : r_fill + CNT_W'(1);
    assign w_changed  = r_valid && (w_bin != r_bin);

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_bin     <= '0;
            r_fill    <= '0;
            r_valid   <= 1'b0;
            r_changed <= 1'b0;
        end else begin
            r_bin     <= w_bin;
            r_fill    <= w_fill_nxt;
            r_valid   <= (w_fill_nxt == FILL_MAX);
            r_changed <= w_changed;
        end
    end

    assign bin_o       = r_bin;
    assign bin_valid_o = r_valid;
    assign changed_o   = r_changed;

`ifdef GRAY_STEP_CHECK_EN
    logic            r_step_err;
    logic [SIZE-1:0] w_delta;
    logic            w_step_bad;

    // Only +1 / -1 (mod 2^SIZE) moves are legal; a new error outranks a clear.
    assign w_delta    = w_bin - r_bin;
    assign w_step_bad = w_changed && (w_delta != SIZE'(1)) && (w_delta != '1);

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_step_err <= 1'b0;
        end else if (w_step_bad) begin
            r_step_err <= 1'b1;
        end else if (err_clr_i) begin
            r_step_err <= 1'b0;
        end
    end

    assign step_err_o = r_step_err;
`else
    logic w_unused_err_clr;

    assign w_unused_err_clr = err_clr_i;
    assign step_err_o       = 1'b0;
`endif

endmodule

// File: tb/tb_gray_sync_decoder.sv
// Self-checking bench for gray_sync_decoder (SIZE=4, SYNC_STAGES=2); step-error
// expectations follow whether GRAY_STEP_CHECK_EN is defined.
module tb_gray_sync_decoder;

    localparam int unsigned SIZE = 4;
    localparam int unsigned LAT  = 3;
`ifdef GRAY_STEP_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            srst_i;
    logic            err_clr_i;
    logic [SIZE-1:0] gray_i;
    logic [SIZE-1:0] bin_o;
    logic            bin_valid_o;
    logic            changed_o;
    logic            step_err_o;

    int n_pass  = 0;
    int n_total = 0;

    logic [SIZE-1:0] sb_q[$];

    gray_sync_decoder #(.SIZE(SIZE), .SYNC_STAGES(2)) dut (
        .clk_i       (clk),
        .srst_i      (srst_i),
        .gray_i      (gray_i),
        .err_clr_i   (err_clr_i),
        .bin_o       (bin_o),
        .bin_valid_o (bin_valid_o),
        .changed_o   (changed_o),
        .step_err_o  (step_err_o)
    );

    always #5 clk = ~clk;

    function automatic logic [SIZE-1:0] to_gray(input logic [SIZE-1:0] v);
        return v ^ (v >> 1);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input logic [SIZE-1:0] v);
        srst_i    = 1'b1;
        err_clr_i = 1'b0;
        gray_i    = to_gray(v);
        repeat (2) tick();
        srst_i = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_reset;
        srst_i    = 1'b1;
        err_clr_i = 1'b0;
        gray_i    = 4'b1000;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_total++;
            if (bin_o !== 4'd0 || bin_valid_o !== 1'b0 || changed_o !== 1'b0 || step_err_o !== 1'b0)
                $display("FAIL reset_hold[%0d] got bin=%0d v=%b c=%b e=%b want 0/0/0/0",
                         c, bin_o, bin_valid_o, changed_o, step_err_o);
            else n_pass++;
        end
        srst_i = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            tick();
            n_total++;
            if (bin_valid_o !== (e == 3))
                $display("FAIL release_valid[%0d] got %b want %b", e, bin_valid_o, (e == 3));
            else n_pass++;
            n_total++;
            if (bin_o !== ((e == 3) ? 4'd15 : 4'd0))
                $display("FAIL release_bin[%0d] got %0d want %0d", e, bin_o, (e == 3) ? 15 : 0);
            else n_pass++;
            n_total++;
            if (changed_o !== 1'b0)
                $display("FAIL release_changed[%0d] got %b want 0", e, changed_o);
            else n_pass++;
        end
    endtask

    // Scoreboard sweep: up counts 0..15,0; down counts 0,15..1,0 then jumps to 8.
    task automatic test_sweep(input bit down);
        logic [SIZE-1:0] v, exp_bin, prev, delta;
        logic            exp_chg, exp_err;
        apply_reset(4'd0);
        sb_q.delete();
        prev    = 4'd0;
        exp_err = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i < 17) v = down ? 4'((16 - i) % 16) : 4'(i % 16);
            else        v = down ? 4'd8 : 4'd0;
            gray_i = to_gray(v);
            sb_q.push_back(v);
            tick();
            if (sb_q.size() == LAT) begin
                exp_bin = sb_q.pop_front();
                exp_chg = (exp_bin != prev);
                delta   = exp_bin - prev;
                if (CHK && exp_chg && delta != 4'd1 && delta != 4'd15) exp_err = 1'b1;
                n_total++;
                if (bin_o !== exp_bin)
                    $display("FAIL sweep%0d_bin[%0d] got %0d want %0d", down, i, bin_o, exp_bin);
                else n_pass++;
                n_total++;
                if (changed_o !== exp_chg)
                    $display("FAIL sweep%0d_changed[%0d] got %b want %b", down, i, changed_o, exp_chg);
                else n_pass++;
                n_total++;
                if (step_err_o !== exp_err)
                    $display("FAIL sweep%0d_err[%0d] got %b want %b", down, i, step_err_o, exp_err);
                else n_pass++;
                n_total++;
                if (bin_valid_o !== 1'b1)
                    $display("FAIL sweep%0d_valid[%0d] got %b want 1", down, i, bin_valid_o);
                else n_pass++;
                prev = exp_bin;
            end
        end
    endtask

    task automatic test_illegal_jump;
        apply_reset(4'd0);
        gray_i = 4'b0111;
        for (int e = 1; e <= 2; e++) begin
            tick();
            n_total++;
            if (bin_o !== 4'd0 || changed_o !== 1'b0)
                $display("FAIL jump_lag[%0d] got bin=%0d c=%b want 0/0", e, bin_o, changed_o);
            else n_pass++;
        end
        tick();
        n_total++;
        if (bin_o !== 4'd5 || changed_o !== 1'b1)
            $display("FAIL jump_arrive got bin=%0d c=%b want 5/1", bin_o, changed_o);
        else n_pass++;
        n_total++;
        if (step_err_o !== CHK)
            $display("FAIL jump_err got %b want %b", step_err_o, CHK);
        else n_pass++;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_total++;
            if (changed_o !== 1'b0 || step_err_o !== CHK || bin_o !== 4'd5)
                $display("FAIL jump_hold[%0d] got bin=%0d c=%b e=%b want 5/0/%b",
                         c, bin_o, changed_o, step_err_o, CHK);
            else n_pass++;
        end
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        n_total++;
        if (step_err_o !== 1'b0)
            $display("FAIL jump_clear got %b want 0", step_err_o);
        else n_pass++;
    endtask

    // Runs straight after test_illegal_jump, starting from bin 5.
    task automatic test_clear_collision;
        gray_i = 4'b1101;
        repeat (2) tick();
        err_clr_i = 1'b1;
        tick();
        n_total++;
        if (bin_o !== 4'd9 || changed_o !== 1'b1)
            $display("FAIL collide_arrive got bin=%0d c=%b want 9/1", bin_o, changed_o);
        else n_pass++;
        n_total++;
        if (step_err_o !== CHK)
            $display("FAIL collide_set_wins got %b want %b", step_err_o, CHK);
        else n_pass++;
        tick();
        err_clr_i = 1'b0;
        n_total++;
        if (step_err_o !== 1'b0 || changed_o !== 1'b0)
            $display("FAIL collide_clear got e=%b c=%b want 0/0", step_err_o, changed_o);
        else n_pass++;
    endtask

    task automatic test_mid_reset;
        apply_reset(4'd0);
        for (int v = 1; v <= 6; v++) begin
            gray_i = to_gray(4'(v));
            tick();
        end
        gray_i = to_gray(4'd12);
        repeat (3) tick();
        n_total++;
        if (bin_o !== 4'd12 || step_err_o !== CHK)
            $display("FAIL midrst_pre got bin=%0d e=%b want 12/%b", bin_o, step_err_o, CHK);
        else n_pass++;
        srst_i = 1'b1;
        gray_i = to_gray(4'd3);
        tick();
        srst_i = 1'b0;
        n_total++;
        if (bin_o !== 4'd0 || bin_valid_o !== 1'b0 || changed_o !== 1'b0 || step_err_o !== 1'b0)
            $display("FAIL midrst_reset got bin=%0d v=%b c=%b e=%b want 0/0/0/0",
                     bin_o, bin_valid_o, changed_o, step_err_o);
        else n_pass++;
        for (int e = 1; e <= 4; e++) begin
            tick();
            n_total++;
            if (bin_valid_o !== (e >= 3))
                $display("FAIL midrst_valid[%0d] got %b want %b", e, bin_valid_o, (e >= 3));
            else n_pass++;
            n_total++;
            if (changed_o !== 1'b0)
                $display("FAIL midrst_changed[%0d] got %b want 0", e, changed_o);
            else n_pass++;
        end
        n_total++;
        if (bin_o !== 4'd3)
            $display("FAIL midrst_bin got %0d want 3", bin_o);
        else n_pass++;
    endtask

    initial begin
        srst_i    = 1'b1;
        err_clr_i = 1'b0;
        gray_i    = '0;
        test_reset();
        test_sweep(1'b0);
        test_sweep(1'b1);
        test_illegal_jump();
        test_clear_collision();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
